// File: rtl/snn_timestep_scheduler.sv
// Window sequencer for the SNN core: feeds one spike frame per timestep, collects
// the core's command spikes into saturating counters, then picks the winner by sequential argmax.
module snn_timestep_scheduler #(
    parameter int N_IN     = 16,
    parameter int N_CMD    = 10,
    parameter int T_WINDOW = 32,
    parameter int CNT_W    = 6,
    parameter int TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [N_IN-1:0]   in_spikes,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [N_IN-1:0]   core_spikes,
    output logic              core_valid,
    output logic              core_clear,
    input  logic [N_CMD-1:0]  core_output,
    input  logic              core_out_valid,
    output logic [3:0]        decision_cmd,
    output logic [CNT_W-1:0]  decision_count,
    output logic              decision_valid,
    input  logic              decision_ready,
    output logic              busy,
    output logic              timeout_err
);

    // Handshakes: a transfer happens on any rising edge where valid and ready are both 1;
    // valid never depends on ready, and decision data is held until that transfer.

    localparam int STEP_W = (T_WINDOW > 1) ? $clog2(T_WINDOW) : 1;
    localparam int TMO_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(T_WINDOW - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [3:0]        IDX_LAST  = 4'(N_CMD - 1);
    localparam logic [3:0]        NO_CMD    = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_WAIT,
        S_DECIDE,
        S_OUTPUT
    } state_t;

    state_t              state_q, state_d;
    logic [N_IN-1:0]     core_spikes_q, core_spikes_d;
    logic                core_valid_q, core_valid_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [CNT_W-1:0]    cnt_q [N_CMD];
    logic [CNT_W-1:0]    cnt_d [N_CMD];
    logic [3:0]          idx_q, idx_d;
    logic [3:0]          best_idx_q, best_idx_d;
    logic [CNT_W-1:0]    best_cnt_q, best_cnt_d;
    logic [3:0]          decision_cmd_q, decision_cmd_d;
    logic [CNT_W-1:0]    decision_count_q, decision_count_d;
    logic                timeout_err_q, timeout_err_d;

    logic [CNT_W-1:0]    sel_cnt;
    logic [3:0]          cand_idx;
    logic [CNT_W-1:0]    cand_cnt;

    // Counter under inspection during DECIDE, and the running best after comparing it.
    always_comb begin
        sel_cnt = '0;
        for (int i = 0; i < N_CMD; i++) begin
            if (idx_q == 4'(i)) begin
                sel_cnt = cnt_q[i];
            end
        end
        cand_idx = best_idx_q;
        cand_cnt = best_cnt_q;
        if (sel_cnt > best_cnt_q) begin
            cand_idx = idx_q;
            cand_cnt = sel_cnt;
        end
    end

    always_comb begin
        state_d          = state_q;
        core_spikes_d    = core_spikes_q;
        core_valid_d     = 1'b0;
        step_d           = step_q;
        tmo_d            = tmo_q;
        cnt_d            = cnt_q;
        idx_d            = idx_q;
        best_idx_d       = best_idx_q;
        best_cnt_d       = best_cnt_q;
        decision_cmd_d   = decision_cmd_q;
        decision_count_d = decision_count_q;
        timeout_err_d    = timeout_err_q;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                for (int i = 0; i < N_CMD; i++) begin
                    cnt_d[i] = '0;
                end
                step_d  = '0;
                state_d = S_FEED;
            end
            S_FEED: begin
                if (in_valid) begin
                    core_spikes_d = in_spikes;
                    core_valid_d  = 1'b1;
                    tmo_d         = '0;
                    state_d       = S_WAIT;
                end
            end
            S_WAIT: begin
                tmo_d = tmo_q + TMO_W'(1);
                // Data arriving on the expiry cycle takes priority over the timeout.
                if (core_out_valid || (tmo_q == TMO_LAST)) begin
                    if (core_out_valid) begin
                        for (int i = 0; i < N_CMD; i++) begin
                            if (core_output[i] && (cnt_q[i] != CNT_MAX)) begin
                                cnt_d[i] = cnt_q[i] + CNT_W'(1);
                            end
                        end
                    end else begin
                        timeout_err_d = 1'b1;
                    end
                    if (step_q == LAST_STEP) begin
                        idx_d      = '0;
                        best_idx_d = NO_CMD;
                        best_cnt_d = '0;
                        state_d    = S_DECIDE;
                    end else begin
                        step_d  = step_q + STEP_W'(1);
                        state_d = S_FEED;
                    end
                end
            end
            S_DECIDE: begin
                best_idx_d = cand_idx;
                best_cnt_d = cand_cnt;
                idx_d      = idx_q + 4'd1;
                if (idx_q == IDX_LAST) begin
                    decision_cmd_d   = cand_idx;
                    decision_count_d = cand_cnt;
                    state_d          = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (decision_ready) begin
                    state_d = run ? S_CLEAR : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            core_spikes_q    <= '0;
            core_valid_q     <= 1'b0;
            step_q           <= '0;
            tmo_q            <= '0;
            for (int i = 0; i < N_CMD; i++) begin
                cnt_q[i] <= '0;
            end
            idx_q            <= '0;
            best_idx_q       <= '0;
            best_cnt_q       <= '0;
            decision_cmd_q   <= '0;
            decision_count_q <= '0;
            timeout_err_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            core_spikes_q    <= core_spikes_d;
            core_valid_q     <= core_valid_d;
            step_q           <= step_d;
            tmo_q            <= tmo_d;
            for (int i = 0; i < N_CMD; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            idx_q            <= idx_d;
            best_idx_q       <= best_idx_d;
            best_cnt_q       <= best_cnt_d;
            decision_cmd_q   <= decision_cmd_d;
            decision_count_q <= decision_count_d;
            timeout_err_q    <= timeout_err_d;
        end
    end

    assign in_ready       = (state_q == S_FEED);
    assign core_clear     = (state_q == S_CLEAR);
    assign decision_valid = (state_q == S_OUTPUT);
    assign busy           = (state_q != S_IDLE);
    assign core_spikes    = core_spikes_q;
    assign core_valid     = core_valid_q;
    assign decision_cmd   = decision_cmd_q;
    assign decision_count = decision_count_q;
    assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// Directed bench for snn_timestep_scheduler: drives windows of frames with a scripted core
// response and checks decisions, latency, timeout behaviour, stall hold and mid-window reset.
module tb_snn_timestep_scheduler;

  logic        clk;
  logic        reset;
  logic        run;
  logic [15:0] in_spikes;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] core_spikes;
  logic        core_valid;
  logic        core_clear;
  logic [9:0]  core_output;
  logic        core_out_valid;
  logic [3:0]  decision_cmd;
  logic [5:0]  decision_count;
  logic        decision_valid;
  logic        decision_ready;
  logic        busy;
  logic        timeout_err;

  int n_cmp = 0;
  int n_bad = 0;
  int clear_cnt = 0;
  int clr_base = 0;

  snn_timestep_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .run            (run),
    .in_spikes      (in_spikes),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .core_spikes    (core_spikes),
    .core_valid     (core_valid),
    .core_clear     (core_clear),
    .core_output    (core_output),
    .core_out_valid (core_out_valid),
    .decision_cmd   (decision_cmd),
    .decision_count (decision_count),
    .decision_valid (decision_valid),
    .decision_ready (decision_ready),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (core_clear) clear_cnt <= clear_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One timestep: offer a frame, then answer dly cycles into WAIT (dly<0 withholds the answer).
  task automatic do_step(input logic [15:0] frame, input logic [9:0] outv, input int dly);
    int k;
    k = 0;
    while (!in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_eq("feed_ready", in_ready, 1);
    in_spikes = frame;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("core_valid", core_valid, 1);
    check_eq("core_spikes", core_spikes, frame);
    if (dly >= 0) begin
      repeat (dly) @(negedge clk);
      core_output    = outv;
      core_out_valid = 1'b1;
      @(negedge clk);
      core_out_valid = 1'b0;
      core_output    = '0;
    end
  endtask

  task automatic finish_window(input logic [3:0] exp_cmd, input logic [5:0] exp_cnt,
                               input int hold, input logic exp_busy);
    int k;
    k = 0;
    while (!decision_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_eq("decision_latency", k, 10);
    check_eq("decision_cmd", decision_cmd, exp_cmd);
    check_eq("decision_count", decision_count, exp_cnt);
    check_eq("clears_per_window", clear_cnt - clr_base, 1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("hold_valid", decision_valid, 1);
      check_eq("hold_cmd", decision_cmd, exp_cmd);
      check_eq("hold_count", decision_count, exp_cnt);
      check_eq("hold_in_ready", in_ready, 0);
      check_eq("hold_core_valid", core_valid, 0);
    end
    decision_ready = 1'b1;
    @(negedge clk);
    decision_ready = 1'b0;
    clr_base = clear_cnt;
    check_eq("accept_valid_low", decision_valid, 0);
    check_eq("after_accept_busy", busy, exp_busy);
  endtask

  task automatic check_all_zero();
    check_eq("rst_core_spikes", core_spikes, 0);
    check_eq("rst_core_valid", core_valid, 0);
    check_eq("rst_core_clear", core_clear, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_decision_valid", decision_valid, 0);
    check_eq("rst_decision_cmd", decision_cmd, 0);
    check_eq("rst_decision_count", decision_count, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_timeout_err", timeout_err, 0);
  endtask

  initial begin
    int k;
    logic [9:0] ov;
    reset          = 1'b1;
    run            = 1'b0;
    in_spikes      = '0;
    in_valid       = 1'b0;
    core_output    = '0;
    core_out_valid = 1'b0;
    decision_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_all_zero();
    @(negedge clk);
    check_eq("idle_busy", busy, 0);

    // Window A: cmd2 fires every step
    clr_base = clear_cnt;
    run = 1'b1;
    @(negedge clk);
    check_eq("start_clear", core_clear, 1);
    for (int s = 0; s < 32; s++) begin
      do_step(16'(s * 37 + 1), 10'b0000000100, s % 3);
    end
    finish_window(4'd2, 6'd32, 0, 1'b1);

    // Window B: cmd3 x5 and cmd7 x5, run dropped mid-window, consumer stalls 20 cycles
    for (int s = 0; s < 32; s++) begin
      if (s == 16) run = 1'b0;
      ov = (s < 5) ? 10'b0000001000 : ((s >= 10 && s < 15) ? 10'b0010000000 : 10'b0);
      do_step(16'hA5A5 ^ 16'(s), ov, s % 2);
    end
    finish_window(4'd3, 6'd5, 20, 1'b0);
    repeat (2) @(negedge clk);
    check_eq("idle_after_run_low", busy, 0);
    check_eq("idle_no_clear", core_clear, 0);

    // Window C: silent core plus a stray core_out_valid while in FEED
    clr_base = clear_cnt;
    run = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 32; s++) begin
      if (s == 3) begin
        core_output    = 10'h3FF;
        core_out_valid = 1'b1;
        @(negedge clk);
        core_out_valid = 1'b0;
        core_output    = '0;
      end
      do_step(16'(s), 10'b0, s % 4);
    end
    finish_window(4'hF, 6'd0, 0, 1'b1);
    check_eq("no_timeout_c", timeout_err, 0);

    // Window D: data on the expiry cycle at step 2, genuine timeout at step 4
    for (int s = 0; s < 32; s++) begin
      if (s == 2) begin
        do_step(16'h0F0F, 10'b0000100000, 14);
        check_eq("expiry_data_wins", timeout_err, 0);
      end else if (s == 4) begin
        do_step(16'hF0F0, 10'b0, -1);
        k = 0;
        while (!in_ready && k < 40) begin
          @(negedge clk);
          k++;
        end
        check_eq("timeout_wait_cycles", k, 15);
        check_eq("timeout_err_set", timeout_err, 1);
      end else begin
        do_step(16'(s * 3), 10'b0000100000, 1);
      end
    end
    finish_window(4'd5, 6'd31, 0, 1'b1);
    check_eq("timeout_sticky", timeout_err, 1);

    // Window E: reset while waiting on step 10, then a fresh window
    for (int s = 0; s < 10; s++) begin
      do_step(16'(s), 10'b1000000000, 0);
    end
    do_step(16'h1234, 10'b0, -1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    run   = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check_all_zero();
    @(negedge clk);
    check_eq("post_reset_idle", busy, 0);
    clr_base = clear_cnt;
    run = 1'b1;
    @(negedge clk);
    check_eq("post_reset_clear", core_clear, 1);
    for (int s = 0; s < 32; s++) begin
      do_step(16'(s + 100), 10'b1000000000, 0);
    end
    run = 1'b0;
    finish_window(4'd9, 6'd32, 0, 1'b0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
